// File: rtl/sram_1r1w_be_if.sv
// Port bundle for the simple-dual-port byte-enable SRAM: status, read and write ports.
interface sram_1r1w_be_if #(
  parameter int DATA_LEN  = 32,
  parameter int N_ENTRIES = 1024
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int NB = DATA_LEN / 8;

  logic                busy_o;
  logic                rd_en_i;
  logic [AW-1:0]       rd_addr_i;
  logic                rd_valid_o;
  logic [DATA_LEN-1:0] rd_data_o;
  logic                wr_en_i;
  logic [AW-1:0]       wr_addr_i;
  logic [NB-1:0]       wr_be_i;
  logic [DATA_LEN-1:0] wr_data_i;

  modport master (
    input  busy_o, rd_valid_o, rd_data_o,
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i
  );

  modport slave (
    output busy_o, rd_valid_o, rd_data_o,
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_be_i, wr_data_i
  );
endinterface

// File: rtl/sram_1r1w_be.sv
// Simple-dual-port SRAM with byte enables, write-first collision merge, 1/2-cycle
// read latency and a post-reset clear sequence that zeroes the whole array.
module sram_1r1w_be #(
  parameter int DATA_LEN       = 32,
  parameter int N_ENTRIES      = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            reset,
  sram_1r1w_be_if.slave  bus
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int NB = DATA_LEN / 8;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_cnt;
  logic [AW-1:0]       w_cnt_nxt;
  logic                w_busy;
  logic                w_rd_fire;
  logic                w_wr_fire;
  logic                w_wr_en;
  logic [AW-1:0]       w_wr_addr;
  logic [NB-1:0]       w_wr_be;
  logic [DATA_LEN-1:0] w_wr_data;
  logic [DATA_LEN-1:0] r_mem [N_ENTRIES];
  logic [DATA_LEN-1:0] r_rd_word;
  logic [DATA_LEN-1:0] r_fwd_data;
  logic [NB-1:0]       r_fwd_be;
  logic                r_v1;
  logic [DATA_LEN-1:0] w_merged;

  function automatic logic [DATA_LEN-1:0] merge_bytes(
    input logic [DATA_LEN-1:0] old_w,
    input logic [DATA_LEN-1:0] new_w,
    input logic [NB-1:0]       be
  );
    logic [DATA_LEN-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      else       res[8*k +: 8] = old_w[8*k +: 8];
    end
    return res;
  endfunction

  // state and clear-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_cnt   <= {AW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next state: leave CLEAR once the last address has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1'b1);
        if (r_cnt == AW'(N_ENTRIES - 1)) w_state_nxt = S_READY;
        else                             w_state_nxt = S_CLEAR;
      end
      S_READY: begin
        w_state_nxt = S_READY;
        w_cnt_nxt   = r_cnt;
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = {AW{1'b0}};
      end
    endcase
  end

  // write-port mux: the clear sequence owns the write port while busy
  always_comb begin
    w_busy    = (r_state == S_CLEAR);
    w_rd_fire = 1'b0;
    w_wr_fire = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = {AW{1'b0}};
    w_wr_be   = {NB{1'b0}};
    w_wr_data = {DATA_LEN{1'b0}};
    if (w_busy) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_cnt;
      w_wr_be   = {NB{1'b1}};
      w_wr_data = {DATA_LEN{1'b0}};
    end else begin
      w_rd_fire = bus.rd_en_i;
      w_wr_fire = bus.wr_en_i;
      w_wr_en   = bus.wr_en_i;
      w_wr_addr = bus.wr_addr_i;
      w_wr_be   = bus.wr_be_i;
      w_wr_data = bus.wr_data_i;
    end
  end

  // array write port
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (w_wr_be[k]) r_mem[w_wr_addr][8*k +: 8] <= w_wr_data[8*k +: 8];
      end
    end
  end

  // registered array read plus capture of same-address write bytes for the merge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1       <= 1'b0;
      r_rd_word  <= {DATA_LEN{1'b0}};
      r_fwd_data <= {DATA_LEN{1'b0}};
      r_fwd_be   <= {NB{1'b0}};
    end else begin
      r_v1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_word  <= r_mem[bus.rd_addr_i];
        r_fwd_data <= bus.wr_data_i;
        if (w_wr_fire && (bus.wr_addr_i == bus.rd_addr_i)) r_fwd_be <= bus.wr_be_i;
        else                                               r_fwd_be <= {NB{1'b0}};
      end
    end
  end

  assign w_merged = merge_bytes(r_rd_word, r_fwd_data, r_fwd_be);
  assign bus.busy_o = w_busy;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic                r_v2;
      logic [DATA_LEN-1:0] r_data2;

      // extra output stage; data only moves on a valid result so it holds otherwise
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_v2    <= 1'b0;
          r_data2 <= {DATA_LEN{1'b0}};
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_data2 <= w_merged;
        end
      end

      assign bus.rd_valid_o = r_v2;
      assign bus.rd_data_o  = r_data2;
    end else begin : g_lat1
      assign bus.rd_valid_o = r_v1;
      assign bus.rd_data_o  = w_merged;
    end
  endgenerate
endmodule

// File: tb/tb_sram_1r1w_be.sv
// Bench for sram_1r1w_be: DUT A (16 words, latency 1, clear on reset) and
// DUT B (16 words, latency 2, no clear), checked by directed vectors and a reference model.
module tb_sram_1r1w_be;
  localparam int DL = 32;
  localparam int NE = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        rd_en   [2];
  logic [3:0]  rd_addr [2];
  logic        wr_en   [2];
  logic [3:0]  wr_addr [2];
  logic [3:0]  be      [2];
  logic [31:0] wdata   [2];

  sram_1r1w_be_if #(.DATA_LEN(DL), .N_ENTRIES(NE)) ifa ();
  sram_1r1w_be_if #(.DATA_LEN(DL), .N_ENTRIES(NE)) ifb ();

  assign ifa.rd_en_i   = rd_en[0];
  assign ifa.rd_addr_i = rd_addr[0];
  assign ifa.wr_en_i   = wr_en[0];
  assign ifa.wr_addr_i = wr_addr[0];
  assign ifa.wr_be_i   = be[0];
  assign ifa.wr_data_i = wdata[0];
  assign ifb.rd_en_i   = rd_en[1];
  assign ifb.rd_addr_i = rd_addr[1];
  assign ifb.wr_en_i   = wr_en[1];
  assign ifb.wr_addr_i = wr_addr[1];
  assign ifb.wr_be_i   = be[1];
  assign ifb.wr_data_i = wdata[1];

  sram_1r1w_be #(.DATA_LEN(DL), .N_ENTRIES(NE), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset(rst[0]), .bus(ifa));
  sram_1r1w_be #(.DATA_LEN(DL), .N_ENTRIES(NE), .READ_LAT(2), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .reset(rst[1]), .bus(ifb));

  logic        busy_obs  [2];
  logic        valid_obs [2];
  logic [31:0] data_obs  [2];
  assign busy_obs[0]  = ifa.busy_o;
  assign valid_obs[0] = ifa.rd_valid_o;
  assign data_obs[0]  = ifa.rd_data_o;
  assign busy_obs[1]  = ifb.busy_o;
  assign valid_obs[1] = ifb.rd_valid_o;
  assign data_obs[1]  = ifb.rd_data_o;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array, clear countdown, and a schedule of results keyed by cycle.
  logic [31:0] mem_m   [2][NE];
  int          clear_left [2];
  logic        sched_v [2][4];
  logic [31:0] sched_d [2][4];
  logic [31:0] last    [2];
  int          ecyc    [2] = '{0, 0};

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic model_reset(input int d);
    clear_left[d] = (d == 0) ? NE : 0;
    for (int a = 0; a < NE; a++) mem_m[d][a] = (d == 0) ? 32'h0 : 32'hxxxxxxxx;
    for (int s = 0; s < 4; s++) sched_v[d][s] = 1'b0;
    last[d] = 32'h0;
  endtask

  task automatic model_edge(input int d);
    logic [31:0] word;
    int slot;
    ecyc[d]++;
    if (rst[d]) return;
    if (clear_left[d] > 0) begin
      clear_left[d]--;
      return;
    end
    if (rd_en[d]) begin
      word = mem_m[d][rd_addr[d]];
      if (wr_en[d] && wr_addr[d] == rd_addr[d])
        for (int k = 0; k < 4; k++) if (be[d][k]) word[8*k +: 8] = wdata[d][8*k +: 8];
      slot = (ecyc[d] + lat_of(d) - 1) % 4;
      sched_v[d][slot] = 1'b1;
      sched_d[d][slot] = word;
    end
    if (wr_en[d])
      for (int k = 0; k < 4; k++) if (be[d][k]) mem_m[d][wr_addr[d]][8*k +: 8] = wdata[d][8*k +: 8];
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int slot;
      slot = ecyc[d] % 4;
      chk((d == 0) ? "A_busy" : "B_busy", {31'd0, busy_obs[d]}, {31'd0, clear_left[d] > 0});
      chk((d == 0) ? "A_valid" : "B_valid", {31'd0, valid_obs[d]}, {31'd0, sched_v[d][slot]});
      if (sched_v[d][slot]) last[d] = sched_d[d][slot];
      sched_v[d][slot] = 1'b0;
      chk((d == 0) ? "A_data" : "B_data", data_obs[d], last[d]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    rd_en[d] = 1'b0; wr_en[d] = 1'b0; be[d] = 4'h0;
  endtask

  typedef struct {
    logic rd; logic [3:0] ra; logic wr; logic [3:0] wa; logic [3:0] be;
    logic [31:0] wd; logic ev; logic [31:0] ed;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 4'd0, 1'b1, 4'd5, 4'hF, 32'hAABBCCDD, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 4'd0, 1'b1, 4'd5, 4'h5, 32'h11223344, 1'b0, 32'h00000000};
    tbl[2]  = '{1'b1, 4'd5, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 32'hAA22CC44};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b0, 32'hAA22CC44};
    tbl[4]  = '{1'b0, 4'd0, 1'b1, 4'd7, 4'hF, 32'h12345678, 1'b0, 32'hAA22CC44};
    tbl[5]  = '{1'b1, 4'd7, 1'b1, 4'd7, 4'h3, 32'hFFFFFFFF, 1'b1, 32'h1234FFFF};
    tbl[6]  = '{1'b1, 4'd7, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 32'h1234FFFF};
    tbl[7]  = '{1'b1, 4'd7, 1'b1, 4'd8, 4'hF, 32'h0BADF00D, 1'b1, 32'h1234FFFF};
    tbl[8]  = '{1'b1, 4'd8, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 32'h0BADF00D};
    tbl[9]  = '{1'b1, 4'd8, 1'b1, 4'd8, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0BADF00D};
    tbl[10] = '{1'b1, 4'd8, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 32'h0BADF00D};
    tbl[11] = '{1'b0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b0, 32'h0BADF00D};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; idle(d); rd_addr[d] = 4'd0; wr_addr[d] = 4'd0; wdata[d] = 32'h0;
      model_reset(d);
    end
    repeat (3) tick();

    // DUT B: no clear, usable on the first edge after release
    rst[1] = 1'b0;
    chk("B_busy_at_release", {31'd0, ifb.busy_o}, 32'd0);
    wr_en[1] = 1'b1; wr_addr[1] = 4'd3; be[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
    tick();
    idle(1); rd_en[1] = 1'b1; rd_addr[1] = 4'd3;
    tick();
    idle(1);
    chk("B_lat2_not_yet", {31'd0, ifb.rd_valid_o}, 32'd0);
    tick();
    chk("B_first_read_valid", {31'd0, ifb.rd_valid_o}, 32'd1);
    chk("B_first_read_data", ifb.rd_data_o, 32'hCAFEF00D);

    // DUT A: clear lasts N_ENTRIES cycles, reads ignored meanwhile
    rst[0] = 1'b0;
    rd_en[0] = 1'b1; rd_addr[0] = 4'd0;
    n = 0;
    while (ifa.busy_o && n < 100) begin
      chk("A_no_valid_while_busy", {31'd0, ifa.rd_valid_o}, 32'd0);
      tick();
      n++;
    end
    idle(0);
    chk("A_clear_cycles", n, 32'd16);
    for (int a = 0; a < NE; a++) begin
      rd_en[0] = 1'b1; rd_addr[0] = 4'(a);
      tick();
      chk("A_cleared_valid", {31'd0, ifa.rd_valid_o}, 32'd1);
      chk("A_cleared_data", ifa.rd_data_o, 32'h0);
    end
    idle(0);

    for (int i = 0; i < 12; i++) begin
      rd_en[0] = tbl[i].rd; rd_addr[0] = tbl[i].ra; wr_en[0] = tbl[i].wr;
      wr_addr[0] = tbl[i].wa; be[0] = tbl[i].be; wdata[0] = tbl[i].wd;
      tick();
      chk("A_tbl_valid", {31'd0, ifa.rd_valid_o}, {31'd0, tbl[i].ev});
      chk("A_tbl_data", ifa.rd_data_o, tbl[i].ed);
    end
    idle(0);

    // DUT B: streaming reads at latency 2
    for (int a = 0; a < 8; a++) begin
      wr_en[1] = 1'b1; wr_addr[1] = 4'(a); be[1] = 4'hF; wdata[1] = 32'(a) * 32'h01010101;
      tick();
    end
    idle(1);
    for (int i = 0; i < 10; i++) begin
      rd_en[1] = (i < 8); rd_addr[1] = 4'(i);
      tick();
      chk("B_stream_valid", {31'd0, ifb.rd_valid_o}, {31'd0, (i >= 1 && i <= 8)});
      if (i >= 1 && i <= 8) chk("B_stream_data", ifb.rd_data_o, 32'(i - 1) * 32'h01010101);
    end
    idle(1);
    tick();
    chk("B_stream_hold", ifb.rd_data_o, 32'h07070707);

    // DUT A: in-flight read dropped by reset, then reset again mid-clear
    wr_en[0] = 1'b1; wr_addr[0] = 4'd9; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
    tick();
    idle(0); rd_en[0] = 1'b1; rd_addr[0] = 4'd9;
    tick();
    idle(0);
    rst[0] = 1'b1; model_reset(0);
    #1;
    chk("A_reset_drops_read", {31'd0, ifa.rd_valid_o}, 32'd0);
    chk("A_reset_data", ifa.rd_data_o, 32'h0);
    tick(); tick();
    rst[0] = 1'b0;
    repeat (9) tick();
    rst[0] = 1'b1; model_reset(0);
    tick();
    chk("A_busy_in_reset", {31'd0, ifa.busy_o}, 32'd1);
    rst[0] = 1'b0;
    n = 0;
    while (ifa.busy_o && n < 100) begin
      tick();
      n++;
    end
    chk("A_restart_clear_cycles", n, 32'd16);
    rd_en[0] = 1'b1; rd_addr[0] = 4'd9;
    tick();
    idle(0);
    chk("A_after_clear_valid", {31'd0, ifa.rd_valid_o}, 32'd1);
    chk("A_after_clear_data", ifa.rd_data_o, 32'h0);

    // fill B completely so random reads hit known contents
    for (int a = 0; a < NE; a++) begin
      wr_en[1] = 1'b1; wr_addr[1] = 4'(a); be[1] = 4'hF; wdata[1] = $urandom;
      tick();
    end
    idle(1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst[0] = 1'b1; model_reset(0);
      end else begin
        rst[0] = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        rd_en[d] = 1'($urandom_range(0, 1));
        wr_en[d] = 1'($urandom_range(0, 1));
        be[d]    = 4'($urandom_range(0, 15));
        wdata[d] = $urandom;
        if ($urandom_range(0, 1) == 0) begin
          rd_addr[d] = 4'($urandom_range(0, 3));
          wr_addr[d] = 4'($urandom_range(0, 3));
        end else begin
          rd_addr[d] = 4'($urandom_range(0, 15));
          wr_addr[d] = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end
    idle(0); idle(1);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_1r1w_be.md
Name: sram_1r1w_be

Overview:
- Parameterised simple-dual-port SRAM (one read port, one write port), successor to the single-port CFU scratch RAM.
- Adds per-byte write enables, selectable read latency (1 or 2), write-to-read forwarding on address collision, and a self-clearing state machine that zeroes the array after reset.
- Sits inside the CFU as an operand/weight buffer: the writer fills it while the compute datapath reads it in the same cycle.

Parameters:
- DATA_LEN, 32, word width in bits; must be a multiple of 8.
- N_ENTRIES, 1024, number of words; power of two, at least 2.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the clear and go straight to READY.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- busy_o  output  1  high while the clear sequence runs; ports are ignored while high.
- rd_en_i  input  1  read request, sampled on the clock edge.
- rd_addr_i  input  $clog2(N_ENTRIES)  read word address.
- rd_valid_o  output  1  one-cycle pulse; rd_data_o is valid this cycle.
- rd_data_o  output  DATA_LEN  read data.
- wr_en_i  input  1  write request.
- wr_addr_i  input  $clog2(N_ENTRIES)  write word address.
- wr_be_i  input  DATA_LEN/8  byte enables; bit k covers data bits [8k+7:8k].
- wr_data_i  input  DATA_LEN  write data.

Behaviour:
- Reset (async assert, sync release):
  - busy_o goes to CLEAR_ON_RESET.
  - rd_valid_o = 0 and rd_data_o = 0.
  - Clear counter = 0; all pipeline valid bits = 0.
  - Array contents are not reset asynchronously.
- FSM states: CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - In CLEAR: each cycle writes 0 (all bytes) to address = counter, then increments the counter.
  - When counter = N_ENTRIES-1 is written, move to READY on the next edge. The clear therefore takes exactly N_ENTRIES cycles after reset release.
  - busy_o is high throughout CLEAR and low in READY.
  - Reset asserted mid-clear returns to CLEAR with counter = 0; the clear restarts from address 0.
- In CLEAR, rd_en_i and wr_en_i are ignored: no array write from the port, and no rd_valid_o pulse.
- Write (READY only):
  - When wr_en_i = 1, RAM[wr_addr_i] byte k <= wr_data_i byte k for every k with wr_be_i[k] = 1.
  - Unselected bytes are unchanged.
  - wr_be_i = 0 is a legal no-op.
- Read (READY only):
  - rd_en_i = 1 at edge T: rd_valid_o = 1 and rd_data_o = word during cycle T+READ_LAT, for one cycle.
  - Back-to-back reads sustain one read per cycle; the pipeline never stalls.
- rd_data_o holds its last value when rd_valid_o = 0. It is updated only on a valid result.
- Collision (rd_en_i and wr_en_i both high, rd_addr_i == wr_addr_i, same edge):
  - The returned word is write-first and merged.
  - Bytes with wr_be_i = 1 come from wr_data_i; all other bytes come from the old array contents.
  - Collision at different addresses: there is no interaction.
- Write followed by a read of the same address on the next edge returns the new data; no extra forwarding is needed.
- READ_LAT = 2 adds one output register stage after the array/forward mux. Valid and data are pipelined together.
- A read issued in the last READY cycle before reset assertion is dropped; no rd_valid_o pulse appears after reset.
- Address ports are exactly $clog2(N_ENTRIES) wide; there is no out-of-range case.
- Memory must infer as block RAM: array read registered, forwarding mux after the array read.

Test Plan:
- Reset release with N_ENTRIES = 16, CLEAR_ON_RESET = 1:
  - busy_o stays high for exactly 16 cycles, then goes low.
  - Reads of addresses 0..15 all return 0x00000000.
  - rd_en_i pulsed during busy_o produces no rd_valid_o.
- Byte-enable write (READ_LAT = 1):
  - Write 0xAABBCCDD to address 5 with be = 0xF.
  - Then write 0x11223344 to address 5 with be = 0x5.
  - Read address 5 returns 0xAA22CC44, with rd_valid_o exactly 1 cycle after rd_en_i.
- Collision:
  - Address 7 holds 0x12345678.
  - On the same edge, write 0xFFFFFFFF with be = 0x3 and read address 7.
  - The read returns 0x1234FFFF; a later read also returns 0x1234FFFF.
- READ_LAT = 2 streaming:
  - Write addresses 0..7 with value = addr*0x01010101.
  - Issue 8 back-to-back reads.
  - rd_valid_o is high for 8 consecutive cycles starting 2 cycles after the first rd_en_i, with data in order.
  - rd_data_o holds 0x07070707 afterwards.
- Reset mid-clear:
  - Assert reset at clear cycle 9 of 16.
  - busy_o stays high, then stays high for 16 full cycles after release.
  - An address written with a nonzero value before reset reads 0 afterwards.
  - An in-flight read produces no rd_valid_o.
- CLEAR_ON_RESET = 0:
  - busy_o = 0 immediately after reset.
  - A write then read of address 3 (0xCAFEF00D) works on the first cycle after reset release.
